// File: rtl/pe_core_kxk.sv
// KxK signed convolution processing element: one full window per cycle, bias or residual add,
// optional ReLU, with a fixed-latency valid pipeline and a weight-load counter.
module pe_core_kxk #(
   parameter int FEATURE_WIDTH      = 16,
   parameter int WEIGHT_WIDTH       = 16,
   parameter int KERNEL_MAX         = 3,
   parameter int MAC_OVERFLOW_WIDTH = 4,
   parameter int BIAS_WIDTH         = WEIGHT_WIDTH + FEATURE_WIDTH,
   parameter int MAC_OUTPUT_WIDTH   = BIAS_WIDTH + MAC_OVERFLOW_WIDTH
) (
   input  logic                                          DSP_clk,
   input  logic                                          rst_n,
   input  logic [WEIGHT_WIDTH-1:0]                       weight,
   input  logic                                          weight_valid,
   input  logic                                          weight_clear,
   output logic                                          weights_ready,
   input  logic                                          kernel_mode,
   input  logic [FEATURE_WIDTH*KERNEL_MAX*KERNEL_MAX-1:0] feature_in,
   input  logic                                          in_valid,
   input  logic [BIAS_WIDTH-1:0]                         bias,
   input  logic                                          bias_valid,
   input  logic [MAC_OUTPUT_WIDTH-1:0]                   adder_feature,
   input  logic                                          bias_or_adder_feature,
   input  logic                                          relu_en,
   output logic [MAC_OUTPUT_WIDTH-1:0]                   feature_out,
   output logic                                          out_valid
);

   localparam int TAPS        = KERNEL_MAX * KERNEL_MAX;
   localparam int TREE_LEVELS = $clog2(TAPS + 1);
   localparam int LATENCY     = TREE_LEVELS + 2;
   localparam int LEAVES      = TAPS + 1;
   localparam int PW          = WEIGHT_WIDTH + FEATURE_WIDTH;
   localparam int CW          = $clog2(TAPS + 1);
   localparam int CENTRE      = (TAPS - 1) / 2;
   localparam int MOW         = MAC_OUTPUT_WIDTH;

   // Number of live nodes at a given adder-tree level; odd leftovers pass through.
   function automatic int level_width(input int lvl);
      int n;
      n = LEAVES;
      for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
      return n;
   endfunction

   logic signed [WEIGHT_WIDTH-1:0] w_q [TAPS];
   logic [CW-1:0]                  cnt_q;
   logic signed [BIAS_WIDTH-1:0]   bias_q;
   logic signed [PW-1:0]           prod [TAPS];
   logic signed [PW-1:0]           prod_1x1;
   logic signed [MOW-1:0]          leaf_d [LEAVES];
   // One spare column keeps the pair index 2*i+1 in range for odd level widths.
   logic signed [MOW-1:0]          tree_q [TREE_LEVELS+1][LEAVES+1];
   logic [LATENCY-1:0]             vld_q;
   logic [TREE_LEVELS:0]           relu_q;
   logic [MOW-1:0]                 out_q;
   logic signed [MOW-1:0]          sum;

   always_ff @(posedge DSP_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < TAPS; p++) w_q[p] <= '0;
         cnt_q  <= '0;
         bias_q <= '0;
      end else begin
         if (weight_valid) begin
            for (int p = 0; p < TAPS - 1; p++) w_q[p] <= w_q[p+1];
            w_q[TAPS-1] <= weight;
         end
         if (weight_clear) cnt_q <= weight_valid ? CW'(1) : '0;
         else if (weight_valid && cnt_q < CW'(TAPS)) cnt_q <= cnt_q + CW'(1);
         if (bias_valid) bias_q <= bias;
      end
   end

   assign weights_ready = kernel_mode ? (cnt_q != '0) : (cnt_q >= CW'(TAPS));

   always_comb begin
      for (int t = 0; t < TAPS; t++) begin
         prod[t] = PW'(w_q[t]) * PW'($signed(feature_in[t*FEATURE_WIDTH +: FEATURE_WIDTH]));
      end
      prod_1x1 = PW'(w_q[TAPS-1]) * PW'($signed(feature_in[CENTRE*FEATURE_WIDTH +: FEATURE_WIDTH]));
      for (int t = 0; t < TAPS; t++) begin
         leaf_d[t] = '0;
         if (!kernel_mode)     leaf_d[t] = MOW'(prod[t]);
         else if (t == CENTRE) leaf_d[t] = MOW'(prod_1x1);
      end
      leaf_d[TAPS] = bias_or_adder_feature ? MOW'(bias_q) : $signed(adder_feature);
   end

   always_ff @(posedge DSP_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l <= TREE_LEVELS; l++)
            for (int i = 0; i <= LEAVES; i++) tree_q[l][i] <= '0;
         vld_q  <= '0;
         relu_q <= '0;
         out_q  <= '0;
      end else begin
         if (in_valid) begin
            for (int i = 0; i < LEAVES; i++) tree_q[0][i] <= leaf_d[i];
         end
         for (int l = 1; l <= TREE_LEVELS; l++) begin
            for (int i = 0; i < (LEAVES + 1) / 2; i++) begin
               if (2*i + 1 < level_width(l-1))
                  tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
               else if (2*i < level_width(l-1))
                  tree_q[l][i] <= tree_q[l-1][2*i];
               else
                  tree_q[l][i] <= '0;
            end
         end
         vld_q  <= {vld_q[LATENCY-2:0], in_valid};
         relu_q <= {relu_q[TREE_LEVELS-1:0], relu_en};
         if (vld_q[TREE_LEVELS])
            out_q <= (relu_q[TREE_LEVELS] && sum[MOW-1]) ? '0 : sum;
      end
   end

   assign sum         = tree_q[TREE_LEVELS][0];
   assign feature_out = out_q;
   assign out_valid   = vld_q[LATENCY-1];

endmodule

// File: tb/tb_pe_core_kxk.sv
// Directed bench for pe_core_kxk at K=3: weight load, bias/residual paths, ReLU,
// 1x1 mode, streaming order, reset flush and load-counter clear.
module tb_pe_core_kxk;

   localparam int FW   = 16;
   localparam int WW   = 16;
   localparam int BW   = 32;
   localparam int MOW  = 36;
   localparam int TAPS = 9;

   logic                 DSP_clk;
   logic                 rst_n;
   logic [WW-1:0]        weight;
   logic                 weight_valid;
   logic                 weight_clear;
   logic                 weights_ready;
   logic                 kernel_mode;
   logic [FW*TAPS-1:0]   feature_in;
   logic                 in_valid;
   logic [BW-1:0]        bias;
   logic                 bias_valid;
   logic [MOW-1:0]       adder_feature;
   logic                 bias_or_adder_feature;
   logic                 relu_en;
   logic [MOW-1:0]       feature_out;
   logic                 out_valid;

   int n_cmp = 0;
   int n_err = 0;
   logic [MOW-1:0] exp_q[$];

   pe_core_kxk dut (
      .DSP_clk(DSP_clk), .rst_n(rst_n),
      .weight(weight), .weight_valid(weight_valid), .weight_clear(weight_clear),
      .weights_ready(weights_ready), .kernel_mode(kernel_mode),
      .feature_in(feature_in), .in_valid(in_valid),
      .bias(bias), .bias_valid(bias_valid), .adder_feature(adder_feature),
      .bias_or_adder_feature(bias_or_adder_feature), .relu_en(relu_en),
      .feature_out(feature_out), .out_valid(out_valid)
   );

   initial DSP_clk = 1'b0;
   always #5 DSP_clk = ~DSP_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [MOW-1:0] obs, input logic [MOW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   task automatic tick();
      @(posedge DSP_clk);
      #1;
   endtask

   task automatic load_w(input int v);
      weight       = WW'(v);
      weight_valid = 1'b1;
      tick();
      weight_valid = 1'b0;
   endtask

   task automatic latch_bias(input int v);
      bias       = BW'(v);
      bias_valid = 1'b1;
      tick();
      bias_valid = 1'b0;
   endtask

   task automatic set_x_all(input int v);
      for (int t = 0; t < TAPS; t++) feature_in[t*FW +: FW] = FW'(v);
   endtask

   // One window; latency counted in edges from the edge that samples in_valid.
   task automatic run_window(input string tag, input logic [MOW-1:0] exp);
      int lat;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, MOW'(lat), MOW'(6));
      check(tag, feature_out, exp);
      tick();
      check({tag, "_pulse"}, MOW'(out_valid), MOW'(0));
   endtask

   initial begin
      rst_n = 1'b0; weight = '0; weight_valid = 1'b0; weight_clear = 1'b0;
      kernel_mode = 1'b0; feature_in = '0; in_valid = 1'b0; bias = '0;
      bias_valid = 1'b0; adder_feature = '0; bias_or_adder_feature = 1'b0; relu_en = 1'b0;
      tick(); tick();
      check("rst_feature_out", feature_out, '0);
      check("rst_out_valid", MOW'(out_valid), '0);
      check("rst_weights_ready", MOW'(weights_ready), '0);
      rst_n = 1'b1;
      tick();

      // Weights 1..9, features 1, bias 10: 45 + 10
      for (int i = 1; i <= 9; i++) begin
         load_w(i);
         if (i == 8) check("ready_after_8", MOW'(weights_ready), MOW'(0));
      end
      check("ready_after_9", MOW'(weights_ready), MOW'(1));
      latch_bias(10);
      bias_or_adder_feature = 1'b1;
      set_x_all(1);
      run_window("bias_55", MOW'(55));

      // Weights -1, features 2: -18, clamped with ReLU; negative bias extension
      for (int i = 0; i < 9; i++) load_w(-1);
      latch_bias(0);
      set_x_all(2);
      run_window("neg_18", MOW'(-18));
      relu_en = 1'b1;
      run_window("relu_0", MOW'(0));
      relu_en = 1'b0;
      latch_bias(-20);
      run_window("neg_bias_38", MOW'(-38));

      // 1x1 mode: 3 * 7 + 5
      kernel_mode = 1'b1;
      weight_clear = 1'b1;
      tick();
      weight_clear = 1'b0;
      check("1x1_ready_cleared", MOW'(weights_ready), MOW'(0));
      load_w(3);
      check("1x1_ready_after_1", MOW'(weights_ready), MOW'(1));
      set_x_all(100);
      feature_in[4*FW +: FW] = FW'(7);
      adder_feature = MOW'(5);
      bias_or_adder_feature = 1'b0;
      run_window("1x1_26", MOW'(26));

      // Stream of 20 windows while weights 9.. shift in; window i sees sum 36 + 9*i
      kernel_mode = 1'b0;
      adder_feature = '0;
      for (int i = 0; i < 9; i++) load_w(i);
      set_x_all(1);
      for (int cyc = 0; cyc < 28; cyc++) begin
         if (cyc < 20) begin
            in_valid = 1'b1;
            weight_valid = 1'b1;
            weight = WW'(9 + cyc);
            exp_q.push_back(MOW'(36 + 9 * cyc));
         end else begin
            in_valid = 1'b0;
            weight_valid = 1'b0;
         end
         tick();
         check("stream_valid", MOW'(out_valid), MOW'((cyc >= 5 && cyc <= 24) ? 1 : 0));
         if (out_valid && exp_q.size() > 0) check("stream_data", feature_out, exp_q.pop_front());
      end
      check("stream_drained", MOW'(exp_q.size()), MOW'(0));

      // Reset three cycles after a window: it must never emerge
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      check("flush_feature_out", feature_out, '0);
      check("flush_weights_ready", MOW'(weights_ready), MOW'(0));
      for (int i = 0; i < 10; i++) begin
         tick();
         check("flush_no_valid", MOW'(out_valid), MOW'(0));
      end

      // Clear together with a load at count 9 leaves count 1
      kernel_mode = 1'b0;
      for (int i = 0; i < 9; i++) load_w(1);
      check("clr_ready_before", MOW'(weights_ready), MOW'(1));
      weight_clear = 1'b1;
      weight_valid = 1'b1;
      weight = WW'(1);
      tick();
      weight_clear = 1'b0;
      weight_valid = 1'b0;
      check("clr_ready_kxk", MOW'(weights_ready), MOW'(0));
      kernel_mode = 1'b1;
      #1;
      check("clr_ready_1x1", MOW'(weights_ready), MOW'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
